half_adder_bist: RTL and testbench
==================================

// Module: half_adder_bist
// PURPOSE
//  Synthesizable built-in self-test driver and checker for the half-adder cell.
//  - Drives operands a/b through all four combinations.
//  - Samples the cell's sum/carry and compares them against a golden model.
//  - Reports pass/fail and an error count.
//  Sits beside the half-adder on-chip, as the hardware counterpart of the bench stimulus side.
// PARAMETERS
//  SETTLE_CYCLES  1   cycles a vector is held before sampling (>=1)
//  NUM_PASSES     1   sweeps over the 4 vectors per run (>=1)
//  ERR_W          8   width of error counter
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      run request; sampled only in IDLE
//  a          out  1      operand A to the half-adder (registered)
//  b          out  1      operand B to the half-adder (registered)
//  sum        in   1      half-adder sum output, combinational from a/b
//  carry      in   1      half-adder carry output, combinational from a/b
//  busy       out  1      high from the cycle after start is accepted until DONE
//  done       out  1      one-cycle pulse at end of run
//  pass       out  1      1 when last completed run had err_count==0; held until next start
//  err_count  out  ERR_W  mismatches in current/last run; saturates at all-ones
// BEHAVIOUR
//  Reset: a=0, b=0, busy=0, done=0, pass=0, err_count=0; FSM=IDLE; all counters 0.
//  FSM states: IDLE -> SETTLE -> CHECK -> (SETTLE | DONE) -> IDLE.
//  - IDLE:   start=1 -> SETTLE.
//            Same edge: clear err_count, clear pass, set vec=2'b00, pass_cnt=0, {a,b}=00.
//  - SETTLE: hold {a,b}=vec for SETTLE_CYCLES cycles, then -> CHECK.
//  - CHECK:  one cycle; at its closing edge:
//            - compare sum vs a^b and carry vs a&b.
//            - Either mismatch -> err_count+1 (one increment per vector max; saturating).
//            - If vec!=3: vec+1, {a,b}=vec+1 -> SETTLE.
//            - If vec==3 and pass_cnt!=NUM_PASSES-1: vec wraps to 0, pass_cnt+1 -> SETTLE.
//            - Else -> DONE.
//  - DONE:   done=1 for exactly this cycle; pass=(err_count==0); {a,b} return to 00; -> IDLE.
//  Vector order: {a,b} = 00, 01, 10, 11 (vec[1]=a, vec[0]=b).
//  Latency: busy high for 4*(SETTLE_CYCLES+1)*NUM_PASSES cycles; done in the following cycle.
//  Boundaries:
//  - start while busy or in DONE: ignored; no restart, no counter effect.
//  - start held high: a new run begins on the first IDLE cycle after DONE.
//  - rst_n low mid-run: immediately (async) all outputs revert to reset values.
//    No done pulse; the partial result is discarded.
//  - err_count at all-ones: stays all-ones; pass=0.
// CONFIGURATION
//  Macro HA_BIST_FAILCAP_EN:
//  - Defined: adds outputs fail_valid (1b) and fail_vec (2b, {a,b}).
//    - Both capture the first mismatching vector of a run and hold it until the next accepted start.
//    - Both are cleared by start and by reset.
//  - Undefined: these ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
//  Package ha_bist_pkg:
//  - state_t enum {IDLE, SETTLE, CHECK, DONE}
//  - VEC_FIRST=2'b00, VEC_LAST=2'b11
//  - settle-counter width function clog2
//  Sub-module ha_ref: combinational golden model, exp_sum=a^b, exp_carry=a&b.
//  - Instantiated once; compared against sum/carry in CHECK.
// TESTING
//  1 Correct half-adder, defaults, start pulse:
//    a/b walk 00,01,10,11 each for 2 cycles; done at cycle 9 after accept; pass=1, err_count=0.
//  2 Carry stuck-at-1, defaults: err_count=3, pass=0.
//    With HA_BIST_FAILCAP_EN: fail_valid=1, fail_vec=2'b00.
//  3 Sum inverted, NUM_PASSES=3: err_count=12, pass=0; busy exactly 24 cycles.
//  4 rst_n pulsed low while {a,b}=01:
//    a=b=0, busy=0, err_count=0 immediately; no done; next start completes normally.
//  5 start re-asserted during SETTLE and on the DONE cycle:
//    no restart; single done pulse; held start launches the next run from IDLE.
//  6 Stuck-at-1 carry, ERR_W=2, NUM_PASSES=2: err_count saturates at 3, pass=0.

Source files
------------

// File: rtl/ha_bist_pkg.sv
// Shared types and constants for the half-adder built-in self-test.
// Optional first-failure capture is enabled by defining HA_BIST_FAILCAP_EN.
package ha_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] VEC_FIRST = 2'b00;
    localparam logic [1:0] VEC_LAST  = 2'b11;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ha_ref.sv
// Combinational golden model of the half-adder cell under test.
module ha_ref (
    input  logic a,
    input  logic b,
    output logic exp_sum,
    output logic exp_carry
);

    assign exp_sum   = a ^ b;
    assign exp_carry = a & b;

endmodule

// File: rtl/half_adder_bist.sv
// BIST driver/checker: sweeps {a,b} over all four vectors and counts sum/carry mismatches.
// Define HA_BIST_FAILCAP_EN to add fail_valid/fail_vec first-mismatch capture.
module half_adder_bist
    import ha_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef HA_BIST_FAILCAP_EN
    ,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
`endif
);

    localparam int CNT_W  = clog2(SETTLE_CYCLES);
    localparam int PASS_W = clog2(NUM_PASSES);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);

    state_t              state;
    logic [1:0]          vec;
    logic [CNT_W-1:0]    settle_cnt;
    logic [PASS_W-1:0]   pass_cnt;
    logic                exp_sum;
    logic                exp_carry;
    logic                mismatch;
    logic [ERR_W-1:0]    err_next;

    ha_ref u_ref (
        .a        (a),
        .b        (b),
        .exp_sum  (exp_sum),
        .exp_carry(exp_carry)
    );

    // At most one increment per vector, holding at all-ones once reached.
    assign mismatch = (sum != exp_sum) || (carry != exp_carry);
    assign err_next = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= VEC_FIRST;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef HA_BIST_FAILCAP_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        vec        <= VEC_FIRST;
                        pass_cnt   <= '0;
                        settle_cnt <= '0;
                        {a, b}     <= VEC_FIRST;
`ifdef HA_BIST_FAILCAP_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'b00;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    err_count <= err_next;
`ifdef HA_BIST_FAILCAP_EN
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= {a, b};
                    end
`endif
                    if (vec != VEC_LAST) begin
                        vec    <= vec + 2'd1;
                        {a, b} <= vec + 2'd1;
                        state  <= SETTLE;
                    end else if (pass_cnt != PASS_LAST) begin
                        vec      <= VEC_FIRST;
                        {a, b}   <= VEC_FIRST;
                        pass_cnt <= pass_cnt + PASS_W'(1);
                        state    <= SETTLE;
                    end else begin
                        // pass uses err_next so the final vector's result is included.
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= (err_next == '0);
                        {a, b} <= 2'b00;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_adder_bist.sv
// Randomized scoreboard bench for half_adder_bist with fault-injecting half-adder models.
// Covers HA_BIST_FAILCAP_EN outputs when that macro is defined.
module tb_half_adder_bist;

    typedef struct {
        int inst;
        int err;
        bit pass;
        int busy;
        bit fv;
        int fvec;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start0, start1;
    logic a0, b0, a1, b1;
    logic sum0, carry0, sum1, carry1;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] err0;
    logic [1:0] err1;
    logic [3:0] sf0, cf0, sf1, cf1;
`ifdef HA_BIST_FAILCAP_EN
    logic       fval0, fval1;
    logic [1:0] fvec0, fvec1;
`endif

    logic busy_w[2];
    logic done_w[2];
    logic pass_w[2];
    int   ab_w[2];
    int   err_w[2];

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_seen0 = 0;

    // Faulty cells: per-vector flip masks on the correct sum/carry.
    assign sum0   = (a0 ^ b0) ^ sf0[{a0, b0}];
    assign carry0 = (a0 & b0) ^ cf0[{a0, b0}];
    assign sum1   = (a1 ^ b1) ^ sf1[{a1, b1}];
    assign carry1 = (a1 & b1) ^ cf1[{a1, b1}];

    half_adder_bist u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .sum(sum0), .carry(carry0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0)
`ifdef HA_BIST_FAILCAP_EN
        , .fail_valid(fval0), .fail_vec(fvec0)
`endif
    );

    half_adder_bist #(.SETTLE_CYCLES(1), .NUM_PASSES(3), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .sum(sum1), .carry(carry1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1)
`ifdef HA_BIST_FAILCAP_EN
        , .fail_valid(fval1), .fail_vec(fvec1)
`endif
    );

    assign busy_w[0] = busy0;
    assign busy_w[1] = busy1;
    assign done_w[0] = done0;
    assign done_w[1] = done1;
    assign pass_w[0] = pass0;
    assign pass_w[1] = pass1;
    assign ab_w[0]   = {30'd0, a0, b0};
    assign ab_w[1]   = {30'd0, a1, b1};
    assign err_w[0]  = {24'd0, err0};
    assign err_w[1]  = {30'd0, err1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference: walk every pass and vector, compare the faulty cell against a+b.
    function automatic exp_t model(input int inst, input logic [3:0] sf, input logic [3:0] cf);
        exp_t e;
        int passes, maxerr, va, vb, ds, dc;
        passes = (inst == 1) ? 3 : 1;
        maxerr = (inst == 1) ? 3 : 255;
        e.inst = inst; e.err = 0; e.fv = 0; e.fvec = 0;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 4; v++) begin
                va = v / 2;
                vb = v % 2;
                ds = ((va + vb) % 2) ^ int'(sf[v]);
                dc = ((va + vb) / 2) ^ int'(cf[v]);
                if (ds != (va + vb) % 2 || dc != (va + vb) / 2) begin
                    if (e.err < maxerr) e.err++;
                    if (!e.fv) begin e.fv = 1; e.fvec = v; end
                end
            end
        end
        e.pass = (e.err == 0);
        e.busy = 4 * 2 * passes;
        return e;
    endfunction

    // Monitor: checks the vector walk while busy and pops the scoreboard on done.
    initial begin : monitor
        int  bcnt[2];
        bit  prev_busy[2];
        exp_t e;
        bcnt[0] = 0; bcnt[1] = 0;
        prev_busy[0] = 0; prev_busy[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt[0] = 0; bcnt[1] = 0;
                prev_busy[0] = 0; prev_busy[1] = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (busy_w[i]) begin
                        check(ab_w[i] == (bcnt[i] / 2) % 4, "ab_walk", ab_w[i], (bcnt[i] / 2) % 4);
                        bcnt[i]++;
                    end
                    if (done_w[i]) begin
                        if (i == 0) done_seen0++;
                        if (sb_q.size() == 0) begin
                            check(1'b0, "unexpected_done", i, -1);
                        end else begin
                            e = sb_q.pop_front();
                            check(e.inst == i, "done_inst", i, e.inst);
                            check(err_w[i] == e.err, "err_count", err_w[i], e.err);
                            check(pass_w[i] == e.pass, "pass", int'(pass_w[i]), int'(e.pass));
                            check(bcnt[i] == e.busy, "busy_cycles", bcnt[i], e.busy);
                            check(prev_busy[i] && !busy_w[i], "done_after_busy", int'(busy_w[i]), 0);
                            check(ab_w[i] == 0, "ab_done", ab_w[i], 0);
`ifdef HA_BIST_FAILCAP_EN
                            if (i == 0) begin
                                check(fval0 == e.fv, "fail_valid", int'(fval0), int'(e.fv));
                                if (e.fv) check(int'(fvec0) == e.fvec, "fail_vec", int'(fvec0), e.fvec);
                            end else begin
                                check(fval1 == e.fv, "fail_valid", int'(fval1), int'(e.fv));
                                if (e.fv) check(int'(fvec1) == e.fvec, "fail_vec", int'(fvec1), e.fvec);
                            end
`endif
                        end
                        bcnt[i] = 0;
                    end
                    prev_busy[i] = busy_w[i];
                end
            end
        end
    end

    task automatic issue(input int inst);
        exp_t e;
        if (inst == 0) e = model(0, sf0, cf0);
        else e = model(1, sf1, cf1);
        sb_q.push_back(e);
        @(negedge clk);
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int limit);
        int k;
        k = 0;
        while (!done_w[inst] && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(done_w[inst], "done_timeout", k, limit);
    endtask

    initial begin : driver
        int inst;
        int k;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        sf0 = '0; cf0 = '0; sf1 = '0; cf1 = '0;
        repeat (3) @(negedge clk);
        check({a0, b0, busy0, done0, pass0} == 5'b0, "reset_ctl0", int'({a0, b0, busy0, done0, pass0}), 0);
        check(err0 == 8'd0, "reset_err0", int'(err0), 0);
        check({a1, b1, busy1, done1, pass1, err1} == 7'b0, "reset_all1", int'({a1, b1, busy1, done1, pass1, err1}), 0);
`ifdef HA_BIST_FAILCAP_EN
        check(!fval0 && !fval1, "reset_fail_valid", int'({fval0, fval1}), 0);
`endif
        rst_n = 1'b1;

        // Good cell, then the directed fault patterns.
        issue(0); wait_done(0, 40);
        repeat (3) @(negedge clk);
        check(pass0 == 1'b1 && err0 == 8'd0, "pass_held", int'({pass0, err0}), 256);
        cf0 = 4'b0111; issue(0); wait_done(0, 40);
        cf0 = 4'b0000; sf0 = 4'b1111; issue(0); wait_done(0, 40);
        sf1 = 4'b1111; issue(1); wait_done(1, 80);
        sf1 = 4'b0000; cf1 = 4'b0111; issue(1); wait_done(1, 80);

        // Random fault masks on random instances.
        for (int n = 0; n < 14; n++) begin
            inst = $urandom_range(0, 1);
            if (inst == 0) begin
                sf0 = 4'($urandom); cf0 = 4'($urandom);
                if ($urandom_range(0, 3) == 0) begin sf0 = '0; cf0 = '0; end
            end else begin
                sf1 = 4'($urandom); cf1 = 4'($urandom);
            end
            issue(inst); wait_done(inst, 80);
        end

        // Asynchronous reset while {a,b}=01 drops the run with no done.
        sf0 = '0; cf0 = '0;
        @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        k = 0;
        while (!(a0 == 1'b0 && b0 == 1'b1) && k < 20) begin @(negedge clk); k++; end
        check(k < 20, "reach_vec01", k, 20);
        done_seen0 = 0;
        #2 rst_n = 1'b0;
        #1;
        check({a0, b0, busy0, done0} == 4'b0, "async_reset_ctl", int'({a0, b0, busy0, done0}), 0);
        check(err0 == 8'd0, "async_reset_err", int'(err0), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check(done_seen0 == 0, "no_done_after_reset", done_seen0, 0);
        issue(0); wait_done(0, 40);

        // start during SETTLE and on the DONE cycle: no restart, held start relaunches.
        cf0 = 4'b1000;
        sb_q.push_back(model(0, sf0, cf0));
        sb_q.push_back(model(0, sf0, cf0));
        @(negedge clk); start0 = 1'b1;
        repeat (2) @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        wait_done(0, 40);
        start0 = 1'b1;
        k = 0;
        while (!busy0 && k < 10) begin @(negedge clk); k++; end
        check(busy0, "held_start_relaunch", k, 10);
        start0 = 1'b0;
        wait_done(0, 40);
        repeat (4) @(negedge clk);
        check(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
